// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - RV32I multi-cycle phase sequencer owning pc and instret
// Optional single-step debug support is compiled in with `define SINGLE_STEP_EN.
module cpu_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 255
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic        mem_ready,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        illegal,
    input  logic        taken_branch,
    input  logic [31:0] branch_target,
    input  logic        halt_req,
`ifdef SINGLE_STEP_EN
    input  logic        step_mode,
    input  logic        step_req,
`endif
    output logic [2:0]  state,
    output logic [31:0] pc,
    output logic        fetch_en,
    output logic        mem_en,
    output logic        wb_en,
    output logic        halted,
    output logic [1:0]  fault,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_READ   = 3'd3,
        S_EXEC   = 3'd4,
        S_MEM    = 3'd5,
        S_WB     = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'd1;
    localparam logic [1:0] FAULT_MISALIGN = 2'd2;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'd3;
    localparam logic [7:0] WAIT_LAST      = 8'(MEM_TIMEOUT - 1);

    state_t      state_q;
    state_t      state_d;
    logic        active;
    logic [7:0]  wait_cnt;
    logic        wait_last;
    logic [31:0] next_pc;
    logic [31:0] next_pc_d;
    logic [1:0]  fault_d;
    logic        commit;

    assign state     = state_q;
    assign wait_last = (wait_cnt == WAIT_LAST);

`ifdef SINGLE_STEP_EN
    logic step_d1;
    logic step_d2;
    logic step_rise;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            step_d1 <= 1'b0;
            step_d2 <= 1'b0;
        end else begin
            step_d1 <= step_req;
            step_d2 <= step_d1;
        end
    end

    assign step_rise = step_d1 & ~step_d2;
`endif

    always_comb begin
        state_d   = state_q;
        fault_d   = fault;
        next_pc_d = next_pc;
        commit    = 1'b0;
        if (!active) begin
            // The reset value of state reads as FETCH, but the real first
            // fetch cycle starts on the first edge after reset release.
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_ready) begin
                        state_d = S_DECODE;
                    end else if (wait_last) begin
                        state_d = S_HALT;
                        fault_d = FAULT_TIMEOUT;
                    end
                end
                S_DECODE: begin
                    if (illegal) begin
                        state_d = S_HALT;
                        fault_d = FAULT_ILLEGAL;
                    end else begin
                        state_d = S_READ;
                    end
                end
                S_READ: state_d = S_EXEC;
                S_EXEC: begin
                    next_pc_d = taken_branch ? branch_target : pc + 32'd4;
                    if (taken_branch && (branch_target[1:0] != 2'b00)) begin
                        state_d = S_HALT;
                        fault_d = FAULT_MISALIGN;
                    end else if (is_load || is_store) begin
                        state_d = S_MEM;
                    end else begin
                        state_d = S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        state_d = S_WB;
                    end else if (wait_last) begin
                        state_d = S_HALT;
                        fault_d = FAULT_TIMEOUT;
                    end
                end
                S_WB: begin
                    commit = 1'b1;
`ifdef SINGLE_STEP_EN
                    state_d = (halt_req || step_mode) ? S_HALT : S_FETCH;
`else
                    state_d = halt_req ? S_HALT : S_FETCH;
`endif
                end
                S_HALT: begin
                    // A faulted core stays here until reset.
                    if (fault == FAULT_NONE) begin
`ifdef SINGLE_STEP_EN
                        if (step_mode) begin
                            if (step_rise) begin
                                state_d = S_FETCH;
                            end
                        end else if (!halt_req) begin
                            state_d = S_FETCH;
                        end
`else
                        if (!halt_req) begin
                            state_d = S_FETCH;
                        end
`endif
                    end
                end
                default: state_d = S_HALT;
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q  <= S_FETCH;
            active   <= 1'b0;
            fetch_en <= 1'b0;
            mem_en   <= 1'b0;
            wb_en    <= 1'b0;
            halted   <= 1'b0;
            fault    <= FAULT_NONE;
            pc       <= RESET_PC;
            next_pc  <= RESET_PC;
            instret  <= 32'd0;
            wait_cnt <= 8'd0;
        end else begin
            active   <= 1'b1;
            state_q  <= state_d;
            fetch_en <= (state_d == S_FETCH);
            mem_en   <= (state_d == S_MEM);
            wb_en    <= (state_d == S_WB);
            halted   <= (state_d == S_HALT);
            fault    <= fault_d;
            next_pc  <= next_pc_d;
            if (commit) begin
                pc      <= next_pc;
                instret <= instret + 32'd1;
            end
            // FETCH->FETCH and MEM->MEM only happen on a wait cycle; any
            // fresh entry into either phase restarts the count.
            if (active && (state_d == state_q) &&
                ((state_d == S_FETCH) || (state_d == S_MEM))) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

    logic        CLK100MHZ = 1'b0;
    logic        CPU_RESETN;
    logic        mem_ready;
    logic        is_load;
    logic        is_store;
    logic        illegal;
    logic        taken_branch;
    logic [31:0] branch_target;
    logic        halt_req;
`ifdef SINGLE_STEP_EN
    logic        step_mode;
    logic        step_req;
`endif
    logic [2:0]  state;
    logic [31:0] pc;
    logic        fetch_en;
    logic        mem_en;
    logic        wb_en;
    logic        halted;
    logic [1:0]  fault;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;
    int wb_cnt = 0;

    always #5 CLK100MHZ = ~CLK100MHZ;

    cpu_sequencer #(
        .RESET_PC    (32'h0000_0000),
        .MEM_TIMEOUT (4)
    ) dut (
        .CLK100MHZ     (CLK100MHZ),
        .CPU_RESETN    (CPU_RESETN),
        .mem_ready     (mem_ready),
        .is_load       (is_load),
        .is_store      (is_store),
        .illegal       (illegal),
        .taken_branch  (taken_branch),
        .branch_target (branch_target),
        .halt_req      (halt_req),
`ifdef SINGLE_STEP_EN
        .step_mode     (step_mode),
        .step_req      (step_req),
`endif
        .state         (state),
        .pc            (pc),
        .fetch_en      (fetch_en),
        .mem_en        (mem_en),
        .wb_en         (wb_en),
        .halted        (halted),
        .fault         (fault),
        .instret       (instret)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK100MHZ);
        if (wb_en) wb_cnt++;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (state !== s && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(state), 32'(s));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(state), 32'd1);
        check({tag, "_pc"}, pc, 32'h0);
        check({tag, "_strobes"}, 32'({fetch_en, mem_en, wb_en, halted}), 32'd0);
        check({tag, "_fault"}, 32'(fault), 32'd0);
        check({tag, "_instret"}, instret, 32'd0);
    endtask

    task automatic async_reset();
        #2 CPU_RESETN = 1'b0;
        #1;
        check_reset_values("async_rst");
        tick();
    endtask

    initial begin
        CPU_RESETN    = 1'b0;
        mem_ready     = 1'b1;
        is_load       = 1'b0;
        is_store      = 1'b0;
        illegal       = 1'b0;
        taken_branch  = 1'b0;
        branch_target = 32'h0;
        halt_req      = 1'b0;
`ifdef SINGLE_STEP_EN
        step_mode     = 1'b0;
        step_req      = 1'b0;
`endif
        tick();
        tick();
        check_reset_values("reset");

        CPU_RESETN = 1'b1;
        tick();
        check("first_fetch_en", 32'(fetch_en), 32'd1);

        // ADDI stream with zero-wait memory
        for (int k = 0; k < 2; k++) begin
            check("addi_fetch_state", 32'(state), 32'd1);
            check("addi_fetch_pc", pc, 32'(4 * k));
            check("addi_instret", instret, 32'(k));
            tick(); check("addi_decode", 32'(state), 32'd2);
            tick(); check("addi_read", 32'(state), 32'd3);
            tick(); check("addi_exec", 32'(state), 32'd4);
            tick(); check("addi_wb", 32'(state), 32'd6);
            check("addi_wb_en", 32'(wb_en), 32'd1);
            tick();
        end
        check("addi_pc2", pc, 32'h8);
        check("addi_instret2", instret, 32'd2);

        // LW with 3 MEM wait cycles: 9 cycles total
        is_load = 1'b1;
        wb_cnt  = 0;
        tick(); tick(); tick();
        check("lw_exec", 32'(state), 32'd4);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("lw_mem_state", 32'(state), 32'd5);
            check("lw_mem_en", 32'(mem_en), 32'd1);
            if (i == 3) mem_ready = 1'b1;
        end
        tick();
        check("lw_wb", 32'(state), 32'd6);
        check("lw_pc_hold", pc, 32'h8);
        is_load = 1'b0;
        tick();
        check("lw_fetch_after_9", 32'(state), 32'd1);
        check("lw_mem_en_low", 32'(mem_en), 32'd0);
        check("lw_wb_pulses", 32'(wb_cnt), 32'd1);
        check("lw_pc", pc, 32'hC);
        check("lw_instret", instret, 32'd3);

        // one ADDI to reach pc=0x10, then taken BEQ to 0x40
        repeat (5) tick();
        check("beq_start_pc", pc, 32'h10);
        taken_branch  = 1'b1;
        branch_target = 32'h40;
        tick(); tick(); tick();
        check("beq_exec_pc", pc, 32'h10);
        tick();
        check("beq_wb_state", 32'(state), 32'd6);
        check("beq_wb_pc", pc, 32'h10);
        taken_branch = 1'b0;
        tick();
        check("beq_pc", pc, 32'h40);
        check("beq_instret", instret, 32'd5);

        // halt_req raised in READ
        tick(); tick();
        check("halt_read", 32'(state), 32'd3);
        halt_req = 1'b1;
        tick(); tick(); tick();
        check("halt_state", 32'(state), 32'd7);
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_strobes", 32'({fetch_en, mem_en, wb_en}), 32'd0);
        check("halt_pc", pc, 32'h44);
        check("halt_instret", instret, 32'd6);
        tick(); tick();
        check("halt_hold", 32'(state), 32'd7);
        halt_req = 1'b0;
        tick();
        check("resume_state", 32'(state), 32'd1);
        check("resume_pc", pc, 32'h44);
        check("resume_halted", 32'(halted), 32'd0);

        // misaligned taken target faults without retiring
        taken_branch  = 1'b1;
        branch_target = 32'h42;
        tick(); tick(); tick();
        tick();
        taken_branch = 1'b0;
        check("misalign_state", 32'(state), 32'd7);
        check("misalign_fault", 32'(fault), 32'd2);
        check("misalign_pc", pc, 32'h44);
        check("misalign_instret", instret, 32'd6);
        halt_req = 1'b1; tick(); halt_req = 1'b0; tick(); tick();
        check("misalign_sticky", 32'(state), 32'd7);
        check("misalign_fault_sticky", 32'(fault), 32'd2);
        async_reset();

        // fetch timeout with MEM_TIMEOUT=4
        mem_ready  = 1'b0;
        CPU_RESETN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("to_fetch_wait", 32'(state), 32'd1);
        end
        tick();
        check("to_state", 32'(state), 32'd7);
        check("to_fault", 32'(fault), 32'd3);
        halt_req = 1'b1; tick(); tick(); halt_req = 1'b0; tick(); tick();
        check("to_sticky", 32'(state), 32'd7);
        async_reset();
        mem_ready = 1'b1;

`ifdef SINGLE_STEP_EN
        step_mode  = 1'b1;
        CPU_RESETN = 1'b1;
        tick();
        wait_state(3'd7, 20, "step_first_halt");
        check("step_first_instret", instret, 32'd1);
        check("step_first_fault", 32'(fault), 32'd0);
        step_req = 1'b1; tick(); step_req = 1'b0;
        wait_state(3'd1, 10, "step_fetch");
        wait_state(3'd7, 20, "step_halt");
        check("step_instret", instret, 32'd2);
        step_req = 1'b1;
        repeat (20) tick();
        step_req = 1'b0;
        check("step_hold_state", 32'(state), 32'd7);
        check("step_hold_instret", instret, 32'd3);
        step_mode = 1'b0;
        tick();
        check("step_free_run", 32'(state), 32'd1);
        async_reset();
`endif

        // illegal instruction
        CPU_RESETN = 1'b1;
        tick();
        illegal = 1'b1;
        tick();
        check("ill_decode", 32'(state), 32'd2);
        tick();
        illegal = 1'b0;
        check("ill_state", 32'(state), 32'd7);
        check("ill_fault", 32'(fault), 32'd1);
        check("ill_pc", pc, 32'h0);
        check("ill_instret", instret, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
